// File: rtl/am_demod_pkg.sv
// ---------------------------------------------------------------------------
// am_demod_pkg
// Shared constants, state enum and saturation helper for the AM demod front
// end. Imported by am_source_select and any sibling blocks that need the
// sample width or the envelope bias.
// ---------------------------------------------------------------------------
package am_demod_pkg;

  localparam int SAMPLE_W = 8;
  localparam int NCO_W    = 16;
  localparam int ENV_BIAS = 16384;
  localparam int AM_SHIFT = 23;
  localparam int PIPE_LAT = 3;

  // Output FSM: RUN forwards samples, MUTE blanks the output while the
  // pipeline flushes across a source change.
  typedef enum logic {
    RUN  = 1'b0,
    MUTE = 1'b1
  } src_state_e;

  // Clamp a wide signed product (already shifted down) into one sample.
  function automatic logic signed [SAMPLE_W-1:0] sat_sample(input logic signed [32:0] v);
    if (v > 33'sd127) begin
      return 8'sd127;
    end else if (v < -33'sd128) begin
      return -8'sd128;
    end else begin
      return v[SAMPLE_W-1:0];
    end
  endfunction

endpackage

// File: rtl/switch_debounce.sv
// ---------------------------------------------------------------------------
// switch_debounce
// Two-flop synchronizer followed by a stability-counter debouncer for a
// mechanical board switch or button.
//   i_clk    : sampling clock
//   i_rst    : synchronous active-high reset
//   i_async  : raw asynchronous switch level
//   o_level  : debounced level (0 after reset)
// The debounced level only follows the input once the synchronized level has
// disagreed with it for 2^DBNC_W - 1 consecutive cycles.
// ---------------------------------------------------------------------------
module switch_debounce #(
  parameter int DBNC_W = 20
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_async,
  output logic o_level
);

  logic              r_sync1;
  logic              r_sync2;
  logic              r_deb;
  logic [DBNC_W-1:0] r_dcnt;
  logic [DBNC_W-1:0] w_dcntInc;

  assign w_dcntInc = r_dcnt + DBNC_W'(1);

  // Synchronize the raw level, then count consecutive disagreeing cycles.
  // Any agreement restarts the count, so bounces never accumulate. The flip
  // happens on the cycle the count would reach all-ones.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_deb   <= 1'b0;
      r_dcnt  <= '0;
    end else begin
      r_sync1 <= i_async;
      r_sync2 <= r_sync1;
      if (r_sync2 == r_deb) begin
        r_dcnt <= '0;
      end else if (w_dcntInc == '1) begin
        r_deb  <= r_sync2;
        r_dcnt <= '0;
      end else begin
        r_dcnt <= w_dcntInc;
      end
    end
  end

  assign o_level = r_deb;

endmodule

// File: rtl/am_source_select.sv
// ---------------------------------------------------------------------------
// am_source_select
// Sample-source stage in front of AMdemod. Chooses between live ADC channel A
// and a locally synthesized AM test tone (carrier x envelope), with a debounced
// selector switch and a muted flush window on every switchover.
//   i_clk            : ADC sample clock
//   i_rst            : synchronous active-high reset
//   i_adc_data       : ADC channel A sample
//   i_carrier        : carrier NCO sine (signed)
//   i_mod_data       : modulating tone NCO sine (signed)
//   i_mod_depth      : 0=100%, 1=50%, 2=25%, 3=12.5%
//   i_sel_test_async : raw switch, 1 selects the test signal
//   o_sig_out        : signed sample to AMdemod
//   o_sig_valid      : o_sig_out carries a real sample
//   o_src_test       : active source, 1 = test signal
// ---------------------------------------------------------------------------
module am_source_select
  import am_demod_pkg::*;
#(
  parameter int DBNC_W         = 20,
  parameter int FLUSH_CYCLES   = 8,
  parameter bit ADC_OFFSET_BIN = 1'b0
) (
  input  logic                       i_clk,
  input  logic                       i_rst,
  input  logic [SAMPLE_W-1:0]        i_adc_data,
  input  logic signed [NCO_W-1:0]    i_carrier,
  input  logic signed [NCO_W-1:0]    i_mod_data,
  input  logic [1:0]                 i_mod_depth,
  input  logic                       i_sel_test_async,
  output logic signed [SAMPLE_W-1:0] o_sig_out,
  output logic                       o_sig_valid,
  output logic                       o_src_test
);

  localparam logic [7:0] FLUSH_M1 = 8'(FLUSH_CYCLES - 1);

  logic                       w_deb;
  logic signed [16:0]         w_modExt;
  logic [2:0]                 w_shamt;
  logic signed [16:0]         w_env;
  logic signed [32:0]         w_prod;
  logic signed [32:0]         w_shifted;
  logic [SAMPLE_W-1:0]        w_adcTwos;

  logic signed [NCO_W-1:0]    r_s1Carrier;
  logic signed [16:0]         r_s1Env;
  logic signed [32:0]         r_s2Prod;
  logic signed [SAMPLE_W-1:0] r_s3Test;
  logic [SAMPLE_W-1:0]        r_adcPipe [PIPE_LAT];
  logic [PIPE_LAT:0]          r_fill;

  src_state_e                 r_state;
  src_state_e                 w_stateNext;
  logic [7:0]                 r_mcnt;
  logic                       r_srcTest;

  switch_debounce #(
    .DBNC_W (DBNC_W)
  ) u_sel_debounce (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_async (i_sel_test_async),
    .o_level (w_deb)
  );

  // Envelope = bias + scaled tone; with the bias at half scale and depth at
  // most 100 %, the sum stays in 0..32767 and never needs clamping.
  assign w_modExt  = {i_mod_data[NCO_W-1], i_mod_data};
  assign w_shamt   = {1'b0, i_mod_depth} + 3'd1;
  assign w_env     = $signed(17'(ENV_BIAS)) + (w_modExt >>> w_shamt);
  assign w_prod    = $signed({{17{r_s1Carrier[NCO_W-1]}}, r_s1Carrier}) *
                     $signed({{16{r_s1Env[16]}}, r_s1Env});
  assign w_shifted = r_s2Prod >>> AM_SHIFT;

  // Offset-binary converters only differ from two's complement in the MSB.
  assign w_adcTwos = (ADC_OFFSET_BIN) ? {~i_adc_data[SAMPLE_W-1], i_adc_data[SAMPLE_W-2:0]}
                                      : i_adc_data;

  // Both datapaths run every cycle regardless of the FSM, three stages each,
  // so switching sources never changes latency. r_fill tracks pipeline fill
  // after reset so the first real sample is flagged one cycle after S3 loads.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_s1Carrier <= '0;
      r_s1Env     <= '0;
      r_s2Prod    <= '0;
      r_s3Test    <= '0;
      for (int i = 0; i < PIPE_LAT; i++) begin
        r_adcPipe[i] <= '0;
      end
      r_fill      <= '0;
    end else begin
      r_s1Carrier  <= i_carrier;
      r_s1Env      <= w_env;
      r_s2Prod     <= w_prod;
      r_s3Test     <= sat_sample(w_shifted);
      r_adcPipe[0] <= w_adcTwos;
      for (int i = 1; i < PIPE_LAT; i++) begin
        r_adcPipe[i] <= r_adcPipe[i-1];
      end
      r_fill       <= {r_fill[PIPE_LAT-1:0], 1'b1};
    end
  end

  // State register plus the mute counter and active-source flag that move
  // with it. The source only changes at the end of a mute, and it takes
  // whatever the switch says then, so a reverted switch just wastes a mute.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state   <= RUN;
      r_mcnt    <= '0;
      r_srcTest <= 1'b0;
    end else begin
      r_state <= w_stateNext;
      if (r_state == RUN && w_stateNext == MUTE) begin
        r_mcnt <= FLUSH_M1;
      end else if (r_state == MUTE && r_mcnt != 8'd0) begin
        r_mcnt <= r_mcnt - 8'd1;
      end
      if (r_state == MUTE && r_mcnt == 8'd0) begin
        r_srcTest <= w_deb;
      end
    end
  end

  // Next-state logic: a debounced switch that disagrees with the active
  // source starts a mute; the mute ends when the counter runs out.
  always_comb begin
    w_stateNext = r_state;
    case (r_state)
      RUN:     if (w_deb != r_srcTest) w_stateNext = MUTE;
      MUTE:    if (r_mcnt == 8'd0)     w_stateNext = RUN;
      default: w_stateNext = RUN;
    endcase
  end

  // Output mux and gating: blank during MUTE, otherwise forward the active
  // source's S3 register; valid additionally waits for pipeline fill.
  always_comb begin
    o_sig_out   = '0;
    o_sig_valid = 1'b0;
    if (r_state == RUN) begin
      o_sig_out   = r_srcTest ? r_s3Test : $signed(r_adcPipe[PIPE_LAT-1]);
      o_sig_valid = r_fill[PIPE_LAT];
    end
  end

  assign o_src_test = r_srcTest;

endmodule
